// File: rtl/AXI_define.sv
// AXI bus geometry shared by the memory wrappers.
package AXI_define;
    localparam int AXI_DATA_BITS = 32;
endpackage

// File: rtl/CPU_profile.sv
// CPU-wide configuration shared across the core and its bus wrappers.
package CPU_profile;
    localparam int XLEN = 32;
endpackage

// File: rtl/mem_seq_pkg.sv
// Types and defaults for the IMEM/DMEM memory sequencer.
package mem_seq_pkg;
    typedef enum logic [2:0] {
        IDLE,
        D_REQ,
        D_WAIT,
        I_REQ,
        I_WAIT,
        DONE
    } mem_seq_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/access_timer.sv
// Per-access wait counter; flags expiry once TIMEOUT cycles have elapsed.
module access_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] wait_cnt;

    // Count cycles spent in an access; saturates at the limit so it never wraps.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (en && (wait_cnt != LIMIT)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign expired = (wait_cnt == LIMIT);
endmodule

// File: rtl/mem_seq_arbiter.sv
// Orders each CPU step as an optional DMEM access followed by one IMEM fetch
// over a single shared memory port, stalling the pipeline until both finish.
module mem_seq_arbiter
    import mem_seq_pkg::*;
#(
    parameter int          XLEN    = CPU_profile::XLEN,
    parameter int          STRB_W  = AXI_define::AXI_DATA_BITS / 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ren,
    output logic [XLEN-1:0]   imem_rdata,
    output logic              imem_raddr_handshake,
    output logic              imem_rdata_handshake,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [STRB_W-1:0] dmem_wstrb,
    input  logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              global_stall_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              err_o
);
    mem_seq_state_e state, next_state;

    logic            expired;
    logic            abort;
    logic            tmr_clr;
    logic            tmr_en;
    logic [XLEN-1:0] i_addr_q;
    logic            i_ren_q;
    logic            d_load_q;

    access_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_access_timer (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(expired)
    );

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, handshake pulses, timer control and abort detection.
    // A timeout in a REQ state takes priority over a same-cycle grant; in a
    // WAIT state a same-cycle rvalid wins over the timeout.
    always_comb begin
        next_state           = state;
        imem_raddr_handshake = 1'b0;
        imem_rdata_handshake = 1'b0;
        abort                = 1'b0;
        tmr_en               = 1'b0;
        unique case (state)
            IDLE: begin
                if (dmem_wen || dmem_ren) next_state = D_REQ;
                else if (imem_ren)        next_state = I_REQ;
                else                      next_state = DONE;
            end
            D_REQ: begin
                tmr_en = 1'b1;
                if (expired) begin
                    abort      = 1'b1;
                    next_state = i_ren_q ? I_REQ : DONE;
                end else if (mem_gnt) begin
                    next_state = D_WAIT;
                end
            end
            D_WAIT: begin
                tmr_en = 1'b1;
                if (mem_rvalid || expired) begin
                    abort      = !mem_rvalid;
                    next_state = i_ren_q ? I_REQ : DONE;
                end
            end
            I_REQ: begin
                tmr_en = 1'b1;
                if (expired) begin
                    abort                = 1'b1;
                    imem_raddr_handshake = 1'b1;
                    imem_rdata_handshake = 1'b1;
                    next_state           = DONE;
                end else if (mem_gnt) begin
                    imem_raddr_handshake = 1'b1;
                    next_state           = I_WAIT;
                end
            end
            I_WAIT: begin
                tmr_en = 1'b1;
                if (mem_rvalid || expired) begin
                    abort                = !mem_rvalid;
                    imem_rdata_handshake = 1'b1;
                    next_state           = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        tmr_clr = (next_state != state) && ((next_state == D_REQ) || (next_state == I_REQ));
    end

    assign global_stall_en = (state != DONE);

    // Request latching, downstream command registers, read-data capture, error flag.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
            imem_rdata <= '0;
            dmem_rdata <= '0;
            err_o      <= 1'b0;
            i_addr_q   <= '0;
            i_ren_q    <= 1'b0;
            d_load_q   <= 1'b0;
        end else begin
            mem_req <= (next_state == D_REQ) || (next_state == I_REQ);

            if (state == IDLE) begin
                i_addr_q <= imem_addr;
                i_ren_q  <= imem_ren;
                d_load_q <= dmem_ren && !dmem_wen;
                if (dmem_ren && dmem_wen) err_o <= 1'b1;
            end
            if (abort) err_o <= 1'b1;

            // Fetch entered straight from IDLE takes the live address, since
            // the latch is only being loaded on this same edge.
            if ((state == IDLE) && (next_state == D_REQ)) begin
                mem_we    <= dmem_wen;
                mem_addr  <= dmem_addr;
                mem_wstrb <= dmem_wstrb;
                mem_wdata <= dmem_wdata;
            end else if ((state != I_REQ) && (next_state == I_REQ)) begin
                mem_we    <= 1'b0;
                mem_addr  <= (state == IDLE) ? imem_addr : i_addr_q;
                mem_wstrb <= '0;
            end else if ((state == D_REQ) && (next_state != D_REQ)) begin
                mem_we <= 1'b0;
            end

            if (d_load_q && (state == D_WAIT) && mem_rvalid) begin
                dmem_rdata <= mem_rdata;
            end else if (d_load_q && abort && ((state == D_REQ) || (state == D_WAIT))) begin
                dmem_rdata <= '0;
            end

            if ((state == I_WAIT) && mem_rvalid) begin
                imem_rdata <= mem_rdata;
            end else if (abort && ((state == I_REQ) || (state == I_WAIT))) begin
                imem_rdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_seq_arbiter.sv
// Directed bench for mem_seq_arbiter with a scoreboarded memory responder.
module tb_mem_seq_arbiter;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } acc_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] imem_addr = '0;
    logic        imem_ren = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_raddr_handshake;
    logic        imem_rdata_handshake;
    logic [31:0] dmem_addr = '0;
    logic        dmem_ren = 1'b0;
    logic        dmem_wen = 1'b0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        global_stall_en;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err_o;

    int   n_assert = 0;
    int   n_fail   = 0;
    acc_t acc_q[$];
    logic [31:0] irq[$];

    always #5 ACLK = ~ACLK;

    mem_seq_arbiter #(
        .XLEN   (32),
        .STRB_W (4),
        .TIMEOUT(4)
    ) dut (
        .ACLK                (ACLK),
        .ARESET              (ARESET),
        .imem_addr           (imem_addr),
        .imem_ren            (imem_ren),
        .imem_rdata          (imem_rdata),
        .imem_raddr_handshake(imem_raddr_handshake),
        .imem_rdata_handshake(imem_rdata_handshake),
        .dmem_addr           (dmem_addr),
        .dmem_ren            (dmem_ren),
        .dmem_wen            (dmem_wen),
        .dmem_wstrb          (dmem_wstrb),
        .dmem_wdata          (dmem_wdata),
        .dmem_rdata          (dmem_rdata),
        .global_stall_en     (global_stall_en),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wstrb           (mem_wstrb),
        .mem_wdata           (mem_wdata),
        .mem_gnt             (mem_gnt),
        .mem_rvalid          (mem_rvalid),
        .mem_rdata           (mem_rdata),
        .err_o               (err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                           input logic [31:0] da, input logic [3:0] ws, input logic [31:0] wd);
        imem_ren = ir; imem_addr = ia;
        dmem_ren = dr; dmem_wen = dw; dmem_addr = da; dmem_wstrb = ws; dmem_wdata = wd;
    endtask

    task automatic push_acc(input logic we, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] wd, input logic [31:0] rd);
        acc_t e;
        e.we = we; e.addr = a; e.wstrb = s; e.wdata = wd; e.rdata = rd;
        acc_q.push_back(e);
    endtask

    // Asserts reset at a negedge, checks reset values, releases at the next negedge (DUT then in IDLE).
    task automatic apply_reset(input string tag);
        @(negedge ACLK);
        ARESET = 1'b1;
        set_cpu(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check({tag, "/stall"},      global_stall_en, 1);
        check({tag, "/mem_req"},    mem_req, 0);
        check({tag, "/mem_we"},     mem_we, 0);
        check({tag, "/mem_addr"},   mem_addr, 0);
        check({tag, "/mem_wstrb"},  mem_wstrb, 0);
        check({tag, "/mem_wdata"},  mem_wdata, 0);
        check({tag, "/imem_rdata"}, imem_rdata, 0);
        check({tag, "/dmem_rdata"}, dmem_rdata, 0);
        check({tag, "/err"},        err_o, 0);
        check({tag, "/raddr_hs"},   imem_raddr_handshake, 0);
        check({tag, "/rdata_hs"},   imem_rdata_handshake, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    // Runs one CPU step from its IDLE cycle (cycle 1) and acts as the memory.
    // gw: grant wait cycles, rw: cycles from grant to rvalid, no_rv: never return rvalid.
    task automatic run_step(input string tag, input int gw, input int rw, input bit no_rv,
                            input int exp_len, input int exp_ra, input int exp_rd);
        int   len = 0, ra = 0, rd = 0, gcnt = 0, rcnt = 0, reqc = 0, n_acc;
        bit   pend = 0, chk_i = 0;
        acc_t cur;
        n_acc = acc_q.size();
        for (int cyc = 1; cyc <= 40 && len == 0; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hBAD0BAD0;
            if (chk_i) begin
                check({tag, "/imem_rdata"}, imem_rdata, (irq.size() > 0) ? irq.pop_front() : 32'hXXXXXXXX);
                chk_i = 0;
            end
            if (pend) begin
                if (rcnt > 0) rcnt--;
                if (rcnt == 0 && !no_rv) begin
                    mem_rvalid = 1'b1; mem_rdata = cur.rdata; pend = 0;
                end
            end else if (mem_req) begin
                reqc++;
                check({tag, "/addr_stable"}, mem_addr, (acc_q.size() > 0) ? acc_q[0].addr : 32'hXXXXXXXX);
                if (gcnt == gw) begin
                    mem_gnt = 1'b1;
                    if (acc_q.size() > 0) cur = acc_q.pop_front();
                    else cur = 'x;
                    check({tag, "/mem_we"},    mem_we, cur.we);
                    check({tag, "/mem_wstrb"}, mem_wstrb, cur.wstrb);
                    if (cur.we) check({tag, "/mem_wdata"}, mem_wdata, cur.wdata);
                    pend = 1; rcnt = rw; gcnt = 0;
                end else begin
                    gcnt++;
                end
            end
            #1;
            if (imem_raddr_handshake) ra = cyc;
            if (imem_rdata_handshake) begin rd = cyc; chk_i = 1; end
            if (!global_stall_en) len = cyc;
            @(negedge ACLK);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check({tag, "/step_len"},   len, exp_len);
        check({tag, "/raddr_cyc"},  ra, exp_ra);
        check({tag, "/rdata_cyc"},  rd, exp_rd);
        check({tag, "/req_cycles"}, reqc, n_acc * (gw + 1));
        check({tag, "/acc_left"},   acc_q.size(), 0);
        check({tag, "/ird_left"},   irq.size(), 0);
        check({tag, "/stall_idle"}, global_stall_en, 1);
        check({tag, "/req_idle"},   mem_req, 0);
    endtask

    initial begin
        apply_reset("RST0");

        // Fetch only, zero-wait memory.
        set_cpu(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0);
        push_acc(1'b0, 32'h100, 4'h0, '0, 32'h00000013); irq.push_back(32'h00000013);
        run_step("A", 0, 1, 0, 4, 2, 3);

        // Load then fetch.
        set_cpu(1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 4'hF, 32'h0);
        push_acc(1'b0, 32'h2000, 4'hF, '0, 32'hDEADBEEF);
        push_acc(1'b0, 32'h104, 4'h0, '0, 32'h00100093); irq.push_back(32'h00100093);
        run_step("B", 0, 1, 0, 6, 4, 5);
        check("B/dmem_rdata", dmem_rdata, 32'hDEADBEEF);

        // Store then fetch; the store response data must not reach dmem_rdata.
        set_cpu(1'b1, 32'h108, 1'b0, 1'b1, 32'h2004, 4'h3, 32'h1234);
        push_acc(1'b1, 32'h2004, 4'h3, 32'h1234, 32'hFFFFFFFF);
        push_acc(1'b0, 32'h108, 4'h0, '0, 32'h00208113); irq.push_back(32'h00208113);
        run_step("C", 0, 1, 0, 6, 4, 5);
        check("C/dmem_rdata", dmem_rdata, 32'hDEADBEEF);

        // Grant held off 3 cycles; rvalid lands exactly on the timeout boundary.
        set_cpu(1'b1, 32'h10C, 1'b0, 1'b0, '0, '0, '0);
        push_acc(1'b0, 32'h10C, 4'h0, '0, 32'h00310193); irq.push_back(32'h00310193);
        run_step("D", 3, 1, 0, 7, 5, 6);
        check("D/err", err_o, 0);

        // Load and fetch, each with two grant wait cycles.
        set_cpu(1'b1, 32'h110, 1'b1, 1'b0, 32'h2008, 4'hF, 32'h0);
        push_acc(1'b0, 32'h2008, 4'hF, '0, 32'hCAFEF00D);
        push_acc(1'b0, 32'h110, 4'h0, '0, 32'h11111111); irq.push_back(32'h11111111);
        run_step("E", 2, 1, 0, 10, 8, 9);
        check("E/dmem_rdata", dmem_rdata, 32'hCAFEF00D);
        check("E/err", err_o, 0);

        // Load and store together, no fetch: store wins, error flagged.
        set_cpu(1'b0, 32'h0, 1'b1, 1'b1, 32'h200C, 4'hF, 32'h77);
        push_acc(1'b1, 32'h200C, 4'hF, 32'h77, 32'h0);
        run_step("F", 0, 1, 0, 4, 0, 0);
        check("F/err", err_o, 1);
        check("F/dmem_rdata", dmem_rdata, 32'hCAFEF00D);

        apply_reset("RST1");

        set_cpu(1'b1, 32'h120, 1'b0, 1'b0, '0, '0, '0);
        push_acc(1'b0, 32'h120, 4'h0, '0, 32'h55); irq.push_back(32'h55);
        run_step("G", 0, 1, 0, 4, 2, 3);
        check("G/err", err_o, 0);

        // Fetch whose rvalid never comes: aborted, zero data, handshake still given.
        set_cpu(1'b1, 32'h124, 1'b0, 1'b0, '0, '0, '0);
        push_acc(1'b0, 32'h124, 4'h0, '0, 32'h0); irq.push_back(32'h0);
        run_step("H", 0, 1, 1, 7, 2, 6);
        check("H/err", err_o, 1);

        set_cpu(1'b1, 32'h128, 1'b0, 1'b0, '0, '0, '0);
        push_acc(1'b0, 32'h128, 4'h0, '0, 32'h66); irq.push_back(32'h66);
        run_step("I", 0, 1, 0, 4, 2, 3);
        check("I/err_sticky", err_o, 1);

        // Reset asserted while the fetch is waiting for data.
        set_cpu(1'b1, 32'h300, 1'b0, 1'b0, '0, '0, '0);
        @(negedge ACLK);
        check("J/req", mem_req, 1);
        check("J/addr", mem_addr, 32'h300);
        mem_gnt = 1'b1;
        #1;
        check("J/raddr_hs", imem_raddr_handshake, 1);
        @(negedge ACLK);
        mem_gnt = 1'b0;
        check("J/req_drop", mem_req, 0);
        ARESET = 1'b1;
        #1;
        check("J/rst_req", mem_req, 0);
        check("J/rst_stall", global_stall_en, 1);
        check("J/rst_addr", mem_addr, 0);
        check("J/rst_imem_rdata", imem_rdata, 0);
        check("J/rst_err", err_o, 0);
        check("J/rst_rdata_hs", imem_rdata_handshake, 0);
        @(negedge ACLK);
        ARESET = 1'b0;

        set_cpu(1'b1, 32'h304, 1'b0, 1'b0, '0, '0, '0);
        push_acc(1'b0, 32'h304, 4'h0, '0, 32'h77); irq.push_back(32'h77);
        run_step("K", 0, 1, 0, 4, 2, 3);
        check("K/err", err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
